// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and types for the sequential restoring divider
// Contents: default operand widths, FSM state enum, iteration counter width and last-step value.
package div_pkg;

    localparam int DW_DEF = 32;
    localparam int VW_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One quotient bit per step; the counter runs 0..LAST_STEP inclusive.
    localparam int                 CNT_W     = 6;
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(DW_DEF - 1);

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle for seq_divider
// Signals: start, dividend[DW], divisor[VW] (issuer -> divider);
//          busy, done, quotient[DW], remainder[VW], dz (divider -> issuer).
// Modports: master (issuing controller), slave (divider).
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) ();

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dz
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
// Ports: rem_i[VW+1] partial remainder, bit_i next dividend bit, divisor_i[VW];
//        rem_o[VW+1] next partial remainder, q_o quotient bit.
module div_step #(
    parameter int VW = 16
) (
    input  logic [VW:0]   rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   rem_o,
    output logic          q_o
);

    logic [VW:0] trial;
    logic [VW:0] dvs_ext;

    assign trial   = {rem_i[VW-1:0], bit_i};
    assign dvs_ext = {1'b0, divisor_i};

    // rem_i[VW] is always zero because the remainder stays below the divisor;
    // if it were ever set, the true shifted value would exceed any divisor,
    // so it is folded in as an unconditional "subtract".
    always_comb begin
        if (rem_i[VW] || (trial >= dvs_ext)) begin
            q_o   = 1'b1;
            rem_o = trial - dvs_ext;
        end else begin
            q_o   = 1'b0;
            rem_o = trial;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, 32/16 -> 32 quotient, 16 remainder
// Ports: clk, rst_n (asynchronous, active-low),
//        bus (seq_divider_if.slave): start/dividend/divisor in; busy/done/quotient/remainder/dz out.
// Build option: DIV_ZERO_SHORTCUT_EN - a zero divisor finishes one cycle after accept instead of 32.
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VW:0]     rem_q, rem_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [VW-1:0]   dvs_q, dvs_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [VW-1:0]   remainder_q, remainder_d;
    logic            dz_q, dz_d;
    logic            done_q, done_d;

    logic            accept;
    logic            zero_skip;
    logic            last_step;
    logic [VW:0]     step_rem;
    logic            step_q;

    // The done cycle is already IDLE, so a start held across it is taken there.
    assign accept    = (state_q == IDLE) && bus.start;
    assign last_step = (state_q == RUN) && (cnt_q == LAST_STEP);

`ifdef DIV_ZERO_SHORTCUT_EN
    assign zero_skip = accept && (bus.divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    div_step #(
        .VW(VW)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DW-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && !zero_skip) state_d = RUN;
            RUN:  if (last_step)            state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.done      = done_q;
        bus.quotient  = quo_q;
        bus.remainder = remainder_q;
        bus.dz        = dz_q;
    end

    // Datapath next-state: operand capture, one restoring step per RUN cycle,
    // result publication on the last step.
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        done_d      = 1'b0;

        if (accept) begin
            dvd_d       = bus.dividend;
            dvs_d       = bus.divisor;
            rem_d       = '0;
            cnt_d       = '0;
            quo_d       = '0;
            remainder_d = '0;
            dz_d        = 1'b0;
            if (zero_skip) begin
                // Same values the full iteration would produce for divisor 0.
                quo_d       = '1;
                remainder_d = bus.dividend[VW-1:0];
                dz_d        = 1'b1;
                done_d      = 1'b1;
            end
        end else if (state_q == RUN) begin
            rem_d = step_rem;
            dvd_d = {dvd_q[DW-2:0], 1'b0};
            quo_d = {quo_q[DW-2:0], step_q};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
                remainder_d = step_rem[VW-1:0];
                dz_d        = (dvs_q == '0);
                done_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference model
module tb_seq_divider;

    localparam int DW = 32;
    localparam int VW = 16;

`ifdef DIV_ZERO_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    seq_divider_if #(.DW(DW), .VW(VW)) dut_if ();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned division; divisor 0 gives all-ones quotient,
    // low dividend half as remainder and the dz flag.
    task automatic ref_model(input logic [31:0] a, input logic [15:0] b,
                             output logic [31:0] q, output logic [15:0] r, output logic z);
        logic [31:0] rem32;
        if (b == 16'd0) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
            z = 1'b1;
        end else begin
            q     = a / {16'd0, b};
            rem32 = a % {16'd0, b};
            r     = rem32[15:0];
            z     = 1'b0;
        end
    endtask

    function automatic int exp_latency(input logic [15:0] b);
        return (SHORTCUT && b == 16'd0) ? 0 : 32;
    endfunction

    // Presents operands with start; returns #1 after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [15:0] b, input bit hold);
        @(negedge clk);
        dut_if.start    = 1'b1;
        dut_if.dividend = a;
        dut_if.divisor  = b;
        @(posedge clk);
        #1;
        if (!hold) dut_if.start = 1'b0;
    endtask

    // Counts edges since the accept edge until done is seen (bounded).
    task automatic wait_done(input string tag, input int lat0, input int exp_lat);
        int lat;
        lat = lat0;
        while (!dut_if.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [15:0] b);
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        ref_model(a, b, q, r, z);
        check({tag, "_quotient"}, dut_if.quotient, q);
        check({tag, "_remainder"}, {16'd0, dut_if.remainder}, {16'd0, r});
        check({tag, "_dz"}, {31'd0, dut_if.dz}, {31'd0, z});
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [15:0] b);
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        int          el;
        ref_model(a, b, q, r, z);
        el = exp_latency(b);
        start_op(a, b, 1'b0);
        check({tag, "_busy_after_accept"}, {31'd0, dut_if.busy}, {31'd0, (el != 0)});
        wait_done(tag, 0, el);
        check_result(tag, a, b);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {31'd0, dut_if.done}, 32'd0);
        check({tag, "_quotient_held"}, dut_if.quotient, q);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb32;
        logic [15:0] rb;
        int          sel;
        int          pulses;

        dut_if.start    = 1'b0;
        dut_if.dividend = '0;
        dut_if.divisor  = '0;

        // Reset state
        #12;
        check("reset_busy", {31'd0, dut_if.busy}, 32'd0);
        check("reset_done", {31'd0, dut_if.done}, 32'd0);
        check("reset_quotient", dut_if.quotient, 32'd0);
        check("reset_remainder", {16'd0, dut_if.remainder}, 32'd0);
        check("reset_dz", {31'd0, dut_if.dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle without start: no activity
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dut_if.done || dut_if.busy) pulses++;
        end
        check("idle_no_activity", pulses, 0);

        // Directed operations
        do_op("basic_100_7", 32'd100, 16'd7);
        do_op("mul_inverse", 32'hFFFE_0001, 16'hFFFF);
        do_op("div_by_one", 32'hFFFF_FFFF, 16'd1);
        do_op("div_by_zero", 32'h1234_5678, 16'd0);

        // start while busy is ignored
        start_op(32'd100, 16'd7, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        dut_if.start    = 1'b1;
        dut_if.dividend = 32'h0000_FFFF;
        dut_if.divisor  = 16'd3;
        @(posedge clk);
        #1;
        dut_if.start = 1'b0;
        wait_done("ignored_start", 5, 32);
        check_result("ignored_start", 32'd100, 16'd7);

        // start held across done: second op accepted in the done cycle
        start_op(32'hFFFF_FFFF, 16'd1, 1'b1);
        dut_if.dividend = 32'd1000;
        dut_if.divisor  = 16'd7;
        wait_done("held_first", 0, 32);
        check_result("held_first", 32'hFFFF_FFFF, 16'd1);
        @(posedge clk);
        #1;
        dut_if.start = 1'b0;
        check("held_second_busy", {31'd0, dut_if.busy}, 32'd1);
        check("held_second_done_low", {31'd0, dut_if.done}, 32'd0);
        wait_done("held_second", 0, 32);
        check_result("held_second", 32'd1000, 16'd7);

        // Reset mid-operation
        start_op(32'd1000, 16'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, dut_if.busy}, 32'd0);
        check("midrst_done", {31'd0, dut_if.done}, 32'd0);
        check("midrst_quotient", dut_if.quotient, 32'd0);
        check("midrst_remainder", {16'd0, dut_if.remainder}, 32'd0);
        check("midrst_dz", {31'd0, dut_if.dz}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut_if.done || dut_if.busy) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        do_op("after_reset_50_5", 32'd50, 16'd5);

        // Randomized operations against the reference model
        for (int i = 0; i < 16; i++) begin
            ra   = $urandom;
            rb32 = $urandom;
            sel  = $urandom_range(0, 5);
            if (sel == 0)      rb = 16'd0;
            else if (sel == 1) rb = 16'($urandom_range(1, 15));
            else               rb = rb32[15:0];
            do_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
